// File: rtl/gated_bit_deserializer.sv
// Packs consecutive enabled serial bits into WIDTH-bit words behind a valid/ready
// output register. Enable drop aborts a word (optionally flushing it); dropped words flag overrun.
module gated_bit_deserializer #(
  parameter int unsigned WIDTH         = 8,
  parameter bit          MSB_FIRST     = 1'b1,
  parameter bit          FLUSH_PARTIAL = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           d,
  input  logic                           word_ready,
  input  logic                           clr_overrun,
  output logic [WIDTH-1:0]               word_out,
  output logic                           word_valid,
  output logic                           word_partial,
  output logic [$clog2(WIDTH+1)-1:0]     bit_count,
  output logic                           overrun
);

  localparam int unsigned CountW = $clog2(WIDTH + 1);
  localparam logic [CountW-1:0] LastCount = CountW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic                valid_q, valid_d;
  logic                partial_q, partial_d;
  logic                overrun_q, overrun_d;

  logic [WIDTH-1:0]    shift_base;
  logic [WIDTH-1:0]    shift_in;
  logic                load;
  logic [WIDTH-1:0]    load_word;
  logic                load_partial;

  // A fresh word shifts in from zero so a flushed partial word is zero-padded.
  assign shift_base = (count_q == '0) ? '0 : shift_q;
  assign shift_in   = MSB_FIRST ? {shift_base[WIDTH-2:0], d} : {d, shift_base[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    load         = 1'b0;
    load_word    = shift_q;
    load_partial = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StShift;
          shift_d = shift_in;
          count_d = CountW'(1);
        end
      end
      StShift: begin
        if (enable) begin
          shift_d = shift_in;
          if (count_q == LastCount) begin
            load      = 1'b1;
            load_word = shift_in;
            count_d   = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          state_d = StIdle;
          count_d = '0;
          if (FLUSH_PARTIAL && (count_q != '0)) begin
            load         = 1'b1;
            load_partial = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    partial_d = partial_q;
    overrun_d = overrun_q;
    if (valid_q && word_ready) valid_d = 1'b0;
    if (clr_overrun) overrun_d = 1'b0;
    if (load) begin
      // A word arriving while the register is occupied and stalled is dropped.
      if (!valid_q || word_ready) begin
        word_d    = load_word;
        partial_d = load_partial;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      count_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      partial_q <= partial_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign word_partial = partial_q;
  assign bit_count    = count_q;
  assign overrun      = overrun_q;

endmodule
